// File: rtl/edsac_pkg.sv
// Shared definitions for the mercury delay-line store blocks: default
// geometry and the word-access FSM state encoding.
package edsac_pkg;

  localparam int DEF_WORD_WIDTH = 18;
  localparam int DEF_NUM_WORDS  = 32;

  typedef enum logic [1:0] {
    TANK_IDLE = 2'd0,
    TANK_WAIT = 2'd1,
    TANK_XFER = 2'd2,
    TANK_DONE = 2'd3
  } tank_state_t;

endpackage

// File: rtl/delay_timing.sv
// Minor-cycle timing: digit counter within a word and word counter within
// one revolution of the tank. Reusable by any store sharing this geometry.
module delay_timing
  import edsac_pkg::*;
#(
  parameter int WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int NUM_WORDS  = DEF_NUM_WORDS,
  localparam int AW = $clog2(NUM_WORDS),
  localparam int DW = $clog2(WORD_WIDTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [DW-1:0] digit,
  output logic [AW-1:0] word,
  output logic          digit_last
);

  logic word_last;

  assign digit_last = (digit == DW'(WORD_WIDTH - 1));
  assign word_last  = (word == AW'(NUM_WORDS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit <= '0;
      word  <= '0;
    end else if (digit_last) begin
      digit <= '0;
      word  <= word_last ? '0 : word + 1'b1;
    end else begin
      digit <= digit + 1'b1;
    end
  end

endmodule

// File: rtl/delay_tank.sv
// Recirculating serial store of NUM_WORDS words with a word read/write port
// that waits for the addressed word to reach the tail of the loop.
module delay_tank
  import edsac_pkg::*;
#(
  parameter int WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int NUM_WORDS  = DEF_NUM_WORDS,
  localparam int AW = $clog2(NUM_WORDS),
  localparam int DW = $clog2(WORD_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  data_clr,
  input  logic                  data_in,
  input  logic                  data_in_gate,
  input  logic                  op_valid,
  output logic                  op_ready,
  input  logic                  op_we,
  input  logic [AW-1:0]         op_addr,
  input  logic [WORD_WIDTH-1:0] op_wdata,
  output logic                  rd_valid,
  output logic [WORD_WIDTH-1:0] rd_data,
  output logic                  data_out,
  output logic [AW-1:0]         mon_word,
  output logic [DW-1:0]         mon_digit
);

  localparam int N = NUM_WORDS * WORD_WIDTH;
  localparam logic [AW:0] WORDS_L = (AW + 1)'(NUM_WORDS);

  tank_state_t           state, state_nx;
  logic [N-1:0]          store;
  logic                  tail, head;
  logic                  digit_last;
  logic                  accept, xfer;
  logic                  addr_ok, at_target, at_start;
  logic [AW-1:0]         addr_q, start_word;
  logic [DW-1:0]         start_digit;
  logic                  we_q;
  logic [WORD_WIDTH-1:0] wdata_q;

  delay_timing #(
    .WORD_WIDTH (WORD_WIDTH),
    .NUM_WORDS  (NUM_WORDS)
  ) u_timing (
    .clk        (clk),
    .rst_n      (rst_n),
    .digit      (mon_digit),
    .word       (mon_word),
    .digit_last (digit_last)
  );

  // store[0] always holds the bit at position (mon_word, mon_digit)
  assign tail   = store[0];
  assign accept = op_valid && op_ready;

  // Out-of-range addresses never meet the tail; they complete after one lap
  assign addr_ok   = ({1'b0, addr_q} < WORDS_L);
  assign at_target = addr_ok && (mon_word == addr_q) && (mon_digit == '0);
  assign at_start  = (mon_word == start_word) && (mon_digit == start_digit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= TANK_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    op_ready = 1'b0;
    rd_valid = 1'b0;
    xfer     = 1'b0;
    case (state)
      TANK_IDLE: begin
        op_ready = 1'b1;
        if (op_valid) state_nx = TANK_WAIT;
      end
      TANK_WAIT: begin
        if (at_target) begin
          xfer     = 1'b1;
          state_nx = TANK_XFER;
        end else if (!addr_ok && at_start) begin
          state_nx = TANK_DONE;
        end
      end
      TANK_XFER: begin
        xfer = 1'b1;
        if (digit_last) state_nx = TANK_DONE;
      end
      TANK_DONE: begin
        op_ready = 1'b1;
        rd_valid = 1'b1;
        state_nx = op_valid ? TANK_WAIT : TANK_IDLE;
      end
      default: state_nx = TANK_IDLE;
    endcase
  end

  // Clear beats a word write, which beats the serial gate
  always_comb begin
    head = tail;
    if (!data_clr)          head = 1'b0;
    else if (xfer && we_q)  head = wdata_q[mon_digit];
    else if (data_in_gate)  head = data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      store    <= '0;
      data_out <= 1'b0;
      rd_data  <= '0;
    end else begin
      store    <= {head, store[N-1:1]};
      data_out <= tail;
      if (accept)    rd_data <= '0;
      else if (xfer) rd_data <= {tail, rd_data[WORD_WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q      <= op_addr;
      we_q        <= op_we;
      wdata_q     <= op_wdata;
      start_word  <= mon_word;
      start_digit <= mon_digit;
    end
  end

endmodule

// File: tb/tb_delay_tank.sv
// Directed bench for delay_tank with a 4-word, 4-bit tank (16-bit loop).
module tb_delay_tank;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       data_clr;
  logic       data_in;
  logic       data_in_gate;
  logic       op_valid;
  logic       op_ready;
  logic       op_we;
  logic [1:0] op_addr;
  logic [3:0] op_wdata;
  logic       rd_valid;
  logic [3:0] rd_data;
  logic       data_out;
  logic [1:0] mon_word;
  logic [1:0] mon_digit;

  int tests = 0;
  int fails = 0;

  delay_tank #(
    .WORD_WIDTH (4),
    .NUM_WORDS  (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_clr     (data_clr),
    .data_in      (data_in),
    .data_in_gate (data_in_gate),
    .op_valid     (op_valid),
    .op_ready     (op_ready),
    .op_we        (op_we),
    .op_addr      (op_addr),
    .op_wdata     (op_wdata),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .data_out     (data_out),
    .mon_word     (mon_word),
    .mon_digit    (mon_digit)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_pos(input int w, input int d);
    int g;
    logic [1:0] ew, ed;
    ew = w[1:0];
    ed = d[1:0];
    g = 0;
    while (!(mon_word == ew && mon_digit == ed) && g < 40) begin
      @(negedge clk);
      g++;
    end
    chk("wait_pos", {mon_word, mon_digit}, {ew, ed});
  endtask

  // Issue one op from a negedge; returns rd_data and the cycle count from
  // the acceptance edge to the cycle carrying rd_valid.
  task automatic do_op(input logic we, input logic [1:0] addr, input logic [3:0] wd,
                       input logic clr_xfer, output logic [3:0] rdata, output int lat);
    int g;
    op_valid = 1'b1;
    op_we    = we;
    op_addr  = addr;
    op_wdata = wd;
    g = 0;
    while (op_ready !== 1'b1 && g < 40) begin
      @(negedge clk);
      g++;
    end
    @(negedge clk);
    op_valid = 1'b0;
    chk("ready_drop", op_ready, 0);
    if (clr_xfer) data_clr = 1'b0;
    lat = 1;
    while (rd_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    data_clr = 1'b1;
    chk("done_valid", rd_valid, 1);
    chk("done_ready", op_ready, 1);
    rdata = rd_data;
    @(negedge clk);
    chk("valid_pulse", rd_valid, 0);
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] a, input logic [3:0] exp);
    logic [3:0] r;
    int l;
    do_op(1'b0, a, 4'h0, 1'b0, r, l);
    chk(tag, r, exp);
    chk("lat_range", (l >= 5 && l <= 21), 1);
  endtask

  initial begin
    logic [3:0]  r;
    int          lat;
    logic [15:0] img;
    int          idx;
    int          nvalid;

    rst_n        = 1'b1;
    data_clr     = 1'b1;
    data_in      = 1'b0;
    data_in_gate = 1'b0;
    op_valid     = 1'b0;
    op_we        = 1'b0;
    op_addr      = 2'd0;
    op_wdata     = 4'h0;
    #2 rst_n = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", op_ready, 1);
    chk("rst_valid", rd_valid, 0);
    chk("rst_rdata", rd_data, 0);
    chk("rst_dout", data_out, 0);
    chk("rst_mon", {mon_word, mon_digit}, 0);
    rst_n = 1'b1;

    // Idle revolution: counters step, stream is all zero
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      chk("idle_mon", {mon_word, mon_digit}, i % 16);
      chk("idle_dout", data_out, 0);
      chk("idle_ready", op_ready, 1);
    end

    // Write word 2 = A, read it back, observe serial stream
    do_op(1'b1, 2'd2, 4'hA, 1'b0, r, lat);
    chk("w2_old", r, 4'h0);
    chk("w2_lat", (lat >= 5 && lat <= 21), 1);
    rd_chk("r2", 2'd2, 4'hA);
    for (int rev = 0; rev < 2; rev++) begin
      img = '0;
      for (int i = 0; i < 16; i++) begin
        @(negedge clk);
        idx = int'({mon_word, mon_digit});
        img[(idx + 15) % 16] = data_out;
      end
      chk("stream_img", img, 16'h0A00);
    end

    // Write word 1 = 5 accepted at counters (1,1): longest-but-one wait
    wait_pos(1, 1);
    do_op(1'b1, 2'd1, 4'h5, 1'b0, r, lat);
    chk("w1_old", r, 4'h0);
    chk("w1_lat", lat, 19);
    rd_chk("r1", 2'd1, 4'h5);

    // Word 3 = 6, then write F with clear held through the transfer
    do_op(1'b1, 2'd3, 4'h6, 1'b0, r, lat);
    chk("w3_old", r, 4'h0);
    wait_pos(2, 3);
    do_op(1'b1, 2'd3, 4'hF, 1'b1, r, lat);
    chk("clr_old", r, 4'h6);
    chk("clr_lat", lat, 5);
    rd_chk("r3_clr", 2'd3, 4'h0);
    rd_chk("r1_keep", 2'd1, 4'h5);
    rd_chk("r2_keep", 2'd2, 4'hA);

    // Serial gate fills the whole loop with ones
    data_in      = 1'b1;
    data_in_gate = 1'b1;
    repeat (16) @(negedge clk);
    data_in_gate = 1'b0;
    data_in      = 1'b0;
    rd_chk("gate_r0", 2'd0, 4'hF);
    rd_chk("gate_r1", 2'd1, 4'hF);
    rd_chk("gate_r2", 2'd2, 4'hF);
    rd_chk("gate_r3", 2'd3, 4'hF);

    // Reset in the middle of a transfer abandons the op
    wait_pos(3, 3);
    op_valid = 1'b1;
    op_we    = 1'b1;
    op_addr  = 2'd0;
    op_wdata = 4'h3;
    @(negedge clk);
    op_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", op_ready, 1);
    chk("mid_rst_valid", rd_valid, 0);
    chk("mid_rst_dout", data_out, 0);
    chk("mid_rst_rdata", rd_data, 0);
    chk("mid_rst_mon", {mon_word, mon_digit}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nvalid = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (rd_valid === 1'b1) nvalid++;
    end
    chk("mid_rst_novalid", nvalid, 0);
    rd_chk("post_rst_r0", 2'd0, 4'h0);
    rd_chk("post_rst_r1", 2'd1, 4'h0);
    rd_chk("post_rst_r2", 2'd2, 4'h0);
    rd_chk("post_rst_r3", 2'd3, 4'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/delay_tank.md
DELAY_TANK -- requirements
Module: delay_tank

Interface
REQ-001 Parameter WORD_WIDTH, default 18, SHALL set the bits per minor cycle (word); legal range 2..64.
REQ-002 Parameter NUM_WORDS, default 32, SHALL set the words per tank revolution; legal range 2..1024, power of two not required.
REQ-003 Port clk, in, 1: single clock; one stored pulse (bit) advances per rising edge.
REQ-004 Port rst_n, in, 1: reset, asynchronous, active-low.
REQ-005 Port data_clr, in, 1: active-low synchronous store clear.
REQ-006 Port data_in, in, 1: serial bit for gated serial write.
REQ-007 Port data_in_gate, in, 1: serial write enable, active-high.
REQ-008 Port op_valid, in, 1: word-operation request.
REQ-009 Port op_ready, out, 1: block can accept a request.
REQ-010 Port op_we, in, 1: 1 = write, 0 = read.
REQ-011 Port op_addr, in, AW = clog2(NUM_WORDS): target word.
REQ-012 Port op_wdata, in, WORD_WIDTH: write word.
REQ-013 Port rd_valid, out, 1: one-cycle pulse when a read or write completes.
REQ-014 Port rd_data, out, WORD_WIDTH: word read; on a write, the previous contents.
REQ-015 Port data_out, out, 1: registered serial tail bit, LSB first.
REQ-016 Ports mon_word (out, AW) and mon_digit (out, clog2(WORD_WIDTH)): current tail word and digit position.

Function
REQ-017 Store SHALL be a recirculating loop of N = NUM_WORDS*WORD_WIDTH bits; each edge moves the tail bit, at position (mon_word, mon_digit), to the head.
REQ-018 mon_digit SHALL increment each edge and wrap WORD_WIDTH-1 -> 0; mon_word SHALL increment on that wrap and wrap NUM_WORDS-1 -> 0.
REQ-019 data_out SHALL register the tail bit each edge; with no writes, the stream repeats with period N.
REQ-020 Head-bit priority SHALL be: data_clr low -> 0; else active op write -> op_wdata[digit]; else data_in_gate high -> data_in; else the tail bit.
REQ-021 A request SHALL be accepted on an edge with op_valid && op_ready; op_addr, op_we and op_wdata are captured then; op_ready drops the next cycle.
REQ-022 FSM SHALL have states IDLE -> WAIT -> XFER -> DONE -> IDLE.
REQ-023 IDLE: op_ready=1; acceptance moves to WAIT.
REQ-024 WAIT: leaves for XFER on the first edge after acceptance where (mon_word, mon_digit) = (addr, 0); that edge processes digit 0.
REQ-025 XFER: processes digits 0..WORD_WIDTH-1 on consecutive edges; each old tail bit shifts into rd_data, LSB first.
REQ-026 DONE: rd_valid=1 for exactly one cycle with the final rd_data; op_ready=1 in the same cycle; back-to-back acceptance is allowed.
REQ-027 Latency, acceptance edge to rd_valid cycle, SHALL be at most N+WORD_WIDTH+1 cycles and at least WORD_WIDTH+1.
REQ-028 data_clr low during XFER SHALL override write bits, but the op SHALL still complete; rd_data returns the old bits.
REQ-029 op_addr >= NUM_WORDS SHALL be accepted and completed after exactly one wait of N cycles with no store change; rd_data = 0.
REQ-030 op_valid while op_ready=0 SHALL be ignored; the requester holds it.

Reset
REQ-031 rst_n low SHALL immediately force: store all 0, counters 0, FSM IDLE, op_ready=1, rd_valid=0, rd_data=0, data_out=0.
REQ-032 Reset during WAIT or XFER SHALL abandon the op with no rd_valid; the partial write is lost because the store is zeroed.

Structure
REQ-033 Shared package edsac_pkg SHALL hold the WORD_WIDTH/NUM_WORDS defaults and the tank FSM state enum.
REQ-034 Sub-module delay_timing SHALL implement the digit/word counters and be reused by later store blocks.

Verification
REQ-035 (WORD_WIDTH=4, NUM_WORDS=4) Release reset -> op_ready=1, mon_word=0, mon_digit=0, data_out=0 for 16 cycles.
REQ-036 Write addr 2 = 4'hA, then read addr 2 -> rd_data=4'hA, rd_valid one cycle; data_out shows 0,1,0,1 during word 2 of each revolution.
REQ-037 Write addr 1 = 4'h5 accepted at counters (1,1) -> WAIT 14 cycles, rd_valid 19 cycles after acceptance.
REQ-038 Write addr 3 = 4'hF with data_clr low for the whole XFER -> readback 4'h0.
REQ-039 data_in_gate high, data_in=1 for 16 cycles -> reads of all 4 words = 4'hF.
REQ-040 rst_n low mid-XFER -> op_ready=1 at once, no rd_valid, all reads 0.
